// File: rtl/recorder_pkg.sv
// Shared types and helpers for the multitrack note recorder.
package recorder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    localparam int MIX_OR  = 0;
    localparam int MIX_SAT = 1;

    // Index width for n entries, never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/track_mem.sv
// One track of note storage: single write port, single registered read port.
module track_mem #(
    parameter int DEPTH  = 64,
    parameter int NOTE_W = 8,
    parameter int AW     = 6
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NOTE_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [NOTE_W-1:0] rd_data
);

    logic [NOTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/multitrack_recorder.sv
// N-track note recorder/player: records into one track, clears tracks, and plays
// a masked subset back at a programmable tick rate through an OR or saturating mix.
module multitrack_recorder
    import recorder_pkg::*;
#(
    parameter int NUM_TRACKS = 4,
    parameter int DEPTH      = 64,
    parameter int NOTE_W     = 8,
    parameter int TICK_DIV   = 25_000_000,
    parameter int MIX_MODE   = 0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 cmd_record,
    input  logic                                 cmd_play,
    input  logic                                 cmd_stop,
    input  logic                                 cmd_clear,
    input  logic [addr_width(NUM_TRACKS)-1:0]    track_sel,
    input  logic [NUM_TRACKS-1:0]                mix_mask,
    input  logic                                 loop,
    input  logic [NOTE_W-1:0]                    note_in,
    input  logic                                 note_valid,
    output logic [NOTE_W-1:0]                    mix_out,
    output logic [addr_width(DEPTH)-1:0]         play_addr,
    output logic                                 busy,
    output logic                                 recording,
    output logic                                 playing,
    output logic                                 full,
    output logic                                 overflow,
    output logic                                 done,
    output logic [addr_width(DEPTH):0]           sel_len
);

    localparam int AW    = addr_width(DEPTH);
    localparam int TW    = addr_width(NUM_TRACKS);
    localparam int CW    = addr_width(TICK_DIV);
    localparam int SUM_W = NOTE_W + TW + 1;

    localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    function automatic logic [NOTE_W-1:0] sat_note(input logic [SUM_W-1:0] s);
        if (|s[SUM_W-1:NOTE_W]) begin
            return '1;
        end
        return s[NOTE_W-1:0];
    endfunction

    state_t                state, state_nxt;
    logic [TW-1:0]         trk;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           len [NUM_TRACKS];
    logic [NUM_TRACKS-1:0] mask;
    logic [AW:0]           limit;
    logic [AW:0]           limit_c;
    logic [CW-1:0]         tick_cnt;
    logic [AW:0]           clr_cnt;

    logic                  accept_rec, accept_play, accept_clr;
    logic                  done_nxt;
    logic                  trk_full, note_wr, note_drop, clr_wr;
    logic                  tick, last_step;

    logic [NUM_TRACKS-1:0] mem_we;
    logic [AW-1:0]         mem_wr_addr;
    logic [NOTE_W-1:0]     mem_wr_data;
    logic [NOTE_W-1:0]     rd_data_p1 [NUM_TRACKS];
    logic [NUM_TRACKS-1:0] en_p1;
    logic                  vld_p1;
    logic [NOTE_W-1:0]     contrib [NUM_TRACKS];
    logic [NOTE_W-1:0]     or_acc;
    logic [SUM_W-1:0]      sum_acc;
    logic [NOTE_W-1:0]     mix_c;

    assign trk_full  = (len[trk] == DEPTH_L);
    assign note_wr   = (state == RECORD) && note_valid && !trk_full;
    assign note_drop = (state == RECORD) && note_valid && trk_full;
    assign clr_wr    = (state == CLEAR) && !clr_cnt[AW];
    assign tick      = (tick_cnt == TICK_LAST);
    assign last_step = tick && ({1'b0, rd_ptr} == (limit - (AW+1)'(1)));

    assign busy      = (state != IDLE);
    assign recording = (state == RECORD);
    assign playing   = (state == PLAY);
    assign full      = (state == RECORD) && trk_full;
    assign play_addr = rd_ptr;

    // Longest masked track sets where playback ends or wraps.
    always_comb begin
        limit_c = '0;
        for (int i = 0; i < NUM_TRACKS; i++) begin
            if (mix_mask[i] && (len[i] > limit_c)) begin
                limit_c = len[i];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        done_nxt    = 1'b0;
        accept_rec  = 1'b0;
        accept_play = 1'b0;
        accept_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_clear) begin
                    accept_clr = 1'b1;
                    state_nxt  = CLEAR;
                end else if (cmd_record) begin
                    accept_rec = 1'b1;
                    state_nxt  = RECORD;
                end else if (cmd_play) begin
                    if (limit_c == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        accept_play = 1'b1;
                        state_nxt   = PLAY;
                    end
                end
            end
            RECORD: begin
                if (cmd_stop) begin
                    state_nxt = IDLE;
                end
            end
            PLAY: begin
                if (cmd_stop) begin
                    state_nxt = IDLE;
                end else if (last_step && !loop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            CLEAR: begin
                if (clr_cnt[AW]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_wr_addr = (state == CLEAR) ? clr_cnt[AW-1:0] : wr_ptr;
    assign mem_wr_data = (state == CLEAR) ? '0 : note_in;

    // p0 -> p1: shared read address, registered RAM output and per-track enable
    for (genvar g = 0; g < NUM_TRACKS; g++) begin : g_track
        assign mem_we[g] = (trk == TW'(g)) && (note_wr || clr_wr);

        track_mem #(
            .DEPTH  (DEPTH),
            .NOTE_W (NOTE_W),
            .AW     (AW)
        ) u_mem (
            .clock   (clock),
            .wr_en   (mem_we[g]),
            .wr_addr (mem_wr_addr),
            .wr_data (mem_wr_data),
            .rd_addr (rd_ptr),
            .rd_data (rd_data_p1[g])
        );

        assign contrib[g] = en_p1[g] ? rd_data_p1[g] : '0;
    end

    always_comb begin
        or_acc  = '0;
        sum_acc = '0;
        for (int i = 0; i < NUM_TRACKS; i++) begin
            or_acc  = or_acc | contrib[i];
            sum_acc = sum_acc + SUM_W'(contrib[i]);
        end
        mix_c = (MIX_MODE == MIX_SAT) ? sat_note(sum_acc) : or_acc;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            trk      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tick_cnt <= '0;
            clr_cnt  <= '0;
            mask     <= '0;
            limit    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            sel_len  <= '0;
            vld_p1   <= 1'b0;
            en_p1    <= '0;
            mix_out  <= '0;
            for (int i = 0; i < NUM_TRACKS; i++) begin
                len[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            done     <= done_nxt;
            overflow <= note_drop;
            sel_len  <= len[track_sel];

            if (accept_rec) begin
                trk            <= track_sel;
                wr_ptr         <= '0;
                len[track_sel] <= '0;
            end
            if (accept_clr) begin
                trk     <= track_sel;
                clr_cnt <= '0;
            end
            if (accept_play) begin
                mask     <= mix_mask;
                limit    <= limit_c;
                rd_ptr   <= '0;
                tick_cnt <= '0;
            end

            if (note_wr) begin
                wr_ptr   <= wr_ptr + AW'(1);
                len[trk] <= len[trk] + (AW+1)'(1);
            end

            if (clr_wr) begin
                clr_cnt <= clr_cnt + (AW+1)'(1);
            end else if ((state == CLEAR) && clr_cnt[AW]) begin
                len[trk] <= '0;
            end

            // Wrap and final step both return to address 0 without a gap cycle.
            if (state == PLAY) begin
                if (cmd_stop) begin
                    rd_ptr   <= '0;
                    tick_cnt <= '0;
                end else if (tick) begin
                    tick_cnt <= '0;
                    rd_ptr   <= last_step ? '0 : rd_ptr + AW'(1);
                end else begin
                    tick_cnt <= tick_cnt + CW'(1);
                end
            end

            // p0 -> p1: contribution gating travels with the RAM read
            vld_p1 <= (state == PLAY);
            for (int i = 0; i < NUM_TRACKS; i++) begin
                en_p1[i] <= mask[i] && ({1'b0, rd_ptr} < len[i]);
            end

            // p1 -> p2: registered mix output
            mix_out <= vld_p1 ? mix_c : '0;
        end
    end

endmodule

// File: tb/tb_multitrack_recorder.sv
// Directed bench: records, mixes, loops, clears and resets two recorders (OR and saturating mix).
module tb_multitrack_recorder;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_record, cmd_play, cmd_stop, cmd_clear;
    logic [1:0] track_sel;
    logic [3:0] mix_mask;
    logic       loop;
    logic [7:0] note_in;
    logic       note_valid;

    logic [7:0] o_mix, s_mix;
    logic [1:0] o_addr, s_addr;
    logic       o_busy, o_rec, o_play, o_full, o_ovf, o_done;
    logic       s_busy, s_rec, s_play, s_full, s_ovf, s_done;
    logic [2:0] o_len, s_len;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    multitrack_recorder #(
        .NUM_TRACKS (4), .DEPTH (4), .NOTE_W (8), .TICK_DIV (4), .MIX_MODE (0)
    ) u_or (
        .clock (clock), .reset (reset),
        .cmd_record (cmd_record), .cmd_play (cmd_play), .cmd_stop (cmd_stop), .cmd_clear (cmd_clear),
        .track_sel (track_sel), .mix_mask (mix_mask), .loop (loop),
        .note_in (note_in), .note_valid (note_valid),
        .mix_out (o_mix), .play_addr (o_addr), .busy (o_busy), .recording (o_rec),
        .playing (o_play), .full (o_full), .overflow (o_ovf), .done (o_done), .sel_len (o_len)
    );

    multitrack_recorder #(
        .NUM_TRACKS (4), .DEPTH (4), .NOTE_W (8), .TICK_DIV (4), .MIX_MODE (1)
    ) u_sat (
        .clock (clock), .reset (reset),
        .cmd_record (cmd_record), .cmd_play (cmd_play), .cmd_stop (cmd_stop), .cmd_clear (cmd_clear),
        .track_sel (track_sel), .mix_mask (mix_mask), .loop (loop),
        .note_in (note_in), .note_valid (note_valid),
        .mix_out (s_mix), .play_addr (s_addr), .busy (s_busy), .recording (s_rec),
        .playing (s_play), .full (s_full), .overflow (s_ovf), .done (s_done), .sel_len (s_len)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_record(input logic [1:0] t);
        track_sel  = t;
        cmd_record = 1'b1;
        step();
        cmd_record = 1'b0;
    endtask

    task automatic note(input logic [7:0] n);
        note_in    = n;
        note_valid = 1'b1;
        step();
        note_valid = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
    endtask

    task automatic pulse_play(input logic [3:0] m);
        mix_mask = m;
        cmd_play = 1'b1;
        step();
        cmd_play = 1'b0;
    endtask

    // Three-address playback at 4 clocks per step, first note 2 clocks after accept.
    function automatic logic [7:0] seq3(input int k, input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        if (k >= 2 && k < 6)   return a;
        if (k >= 6 && k < 10)  return b;
        if (k >= 10 && k < 14) return c;
        return 8'h00;
    endfunction

    initial begin
        reset = 1'b0; cmd_record = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0;
        track_sel = 2'd0; mix_mask = 4'd0; loop = 1'b0; note_in = 8'h00; note_valid = 1'b0;
        step();
        step();
        check("reset mix_out", 32'(o_mix), 32'h0);
        check("reset busy", 32'(o_busy), 32'h0);
        check("reset done", 32'(o_done), 32'h0);
        check("reset sel_len", 32'(o_len), 32'h0);
        check("reset play_addr", 32'(o_addr), 32'h0);
        reset = 1'b1;
        step();

        // Basic record and playback of track 0
        pulse_record(2'd0);
        check("record busy", 32'(o_busy), 32'h1);
        check("record flag", 32'(o_rec), 32'h1);
        note(8'h01);
        note(8'h02);
        note(8'h04);
        pulse_stop();
        step();
        check("basic sel_len", 32'(o_len), 32'h3);
        check("basic idle", 32'(o_busy), 32'h0);
        pulse_play(4'b0001);
        check("basic playing", 32'(o_play), 32'h1);
        for (int k = 1; k <= 15; k++) begin
            step();
            check($sformatf("basic mix k=%0d", k), 32'(o_mix), 32'(seq3(k, 8'h01, 8'h02, 8'h04)));
            check($sformatf("basic done k=%0d", k), 32'(o_done), 32'(k == 12));
            if (k == 5) check("basic play_addr k=5", 32'(o_addr), 32'h1);
            if (k == 9) check("basic play_addr k=9", 32'(o_addr), 32'h2);
        end
        check("basic sel_len after", 32'(o_len), 32'h3);

        // OR mix of tracks 0 and 1
        pulse_record(2'd1);
        note(8'h10);
        note(8'h20);
        pulse_stop();
        step();
        check("track1 sel_len", 32'(o_len), 32'h2);
        pulse_play(4'b0011);
        for (int k = 1; k <= 15; k++) begin
            step();
            check($sformatf("or mix k=%0d", k), 32'(o_mix), 32'(seq3(k, 8'h11, 8'h22, 8'h04)));
            check($sformatf("or done k=%0d", k), 32'(o_done), 32'(k == 12));
            if (k == 7) check("sat inst no clamp k=7", 32'(s_mix), 32'h22);
        end

        // Saturating mix: 0xF0 + 0x20 clamps
        pulse_record(2'd2);
        note(8'hF0);
        pulse_stop();
        pulse_record(2'd3);
        note(8'h20);
        pulse_stop();
        pulse_play(4'b1100);
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("sat mix k=%0d", k), 32'(s_mix), (k >= 2 && k < 6) ? 32'hFF : 32'h0);
            check($sformatf("or of sat pair k=%0d", k), 32'(o_mix), (k >= 2 && k < 6) ? 32'hF0 : 32'h0);
            check($sformatf("sat done k=%0d", k), 32'(s_done), 32'(k == 4));
        end

        // Full track: fifth note is dropped
        pulse_record(2'd3);
        note(8'hA1);
        note(8'hA2);
        note(8'hA3);
        check("full before 4th", 32'(o_full), 32'h0);
        note(8'hA4);
        check("full at 4", 32'(o_full), 32'h1);
        check("no overflow at 4", 32'(o_ovf), 32'h0);
        note(8'hA5);
        check("overflow on 5th", 32'(o_ovf), 32'h1);
        check("full on 5th", 32'(o_full), 32'h1);
        step();
        check("overflow one pulse", 32'(o_ovf), 32'h0);
        pulse_stop();
        check("full cleared on stop", 32'(o_full), 32'h0);
        step();
        check("full sel_len", 32'(o_len), 32'h4);
        pulse_play(4'b1000);
        step();
        step();
        check("addr0 kept", 32'(o_mix), 32'hA1);
        for (int k = 3; k <= 6; k++) step();
        check("addr1 note", 32'(o_mix), 32'hA2);
        pulse_stop();
        check("stop playing", 32'(o_play), 32'h0);
        check("stop no done", 32'(o_done), 32'h0);
        step();
        check("stop no done later", 32'(o_done), 32'h0);
        step();
        check("stop mix zero", 32'(o_mix), 32'h0);

        // Looping two-note track 1
        loop = 1'b1;
        pulse_play(4'b0010);
        for (int k = 1; k <= 18; k++) begin
            step();
            check($sformatf("loop mix k=%0d", k), 32'(o_mix),
                  (k < 2) ? 32'h0 : ((((k - 2) / 4) % 2 == 0) ? 32'h10 : 32'h20));
            check($sformatf("loop no done k=%0d", k), 32'(o_done), 32'h0);
        end
        pulse_stop();
        loop = 1'b0;
        check("loop stop busy", 32'(o_busy), 32'h0);
        step();
        step();
        check("loop stop mix", 32'(o_mix), 32'h0);

        // Clear track 0: DEPTH+1 busy cycles then empty
        track_sel = 2'd0;
        cmd_clear = 1'b1;
        step();
        cmd_clear = 1'b0;
        check("clear busy k=1", 32'(o_busy), 32'h1);
        for (int k = 2; k <= 6; k++) begin
            step();
            check($sformatf("clear busy k=%0d", k), 32'(o_busy), 32'(k <= 5));
        end
        step();
        check("clear sel_len", 32'(o_len), 32'h0);
        pulse_play(4'b0001);
        check("cleared play idle", 32'(o_busy), 32'h0);
        check("cleared play done", 32'(o_done), 32'h1);
        step();
        check("cleared done pulse", 32'(o_done), 32'h0);

        // Clear outranks record in the same cycle
        track_sel  = 2'd3;
        cmd_clear  = 1'b1;
        cmd_record = 1'b1;
        step();
        cmd_clear  = 1'b0;
        cmd_record = 1'b0;
        check("prio not recording", 32'(o_rec), 32'h0);
        check("prio clearing busy", 32'(o_busy), 32'h1);
        for (int k = 0; k < 6; k++) step();
        check("prio cleared len", 32'(o_len), 32'h0);

        // Reset in the middle of playback
        track_sel = 2'd1;
        pulse_play(4'b0010);
        for (int k = 1; k <= 5; k++) step();
        check("pre-reset mix", 32'(o_mix), 32'h10);
        check("pre-reset addr", 32'(o_addr), 32'h1);
        reset = 1'b0;
        step();
        check("rst mix_out", 32'(o_mix), 32'h0);
        check("rst busy", 32'(o_busy), 32'h0);
        check("rst playing", 32'(o_play), 32'h0);
        check("rst play_addr", 32'(o_addr), 32'h0);
        check("rst sel_len", 32'(o_len), 32'h0);
        check("rst done", 32'(o_done), 32'h0);
        reset = 1'b1;
        step();
        pulse_play(4'b0010);
        check("post-reset play idle", 32'(o_busy), 32'h0);
        check("post-reset done", 32'(o_done), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
